// File: rtl/bfp_block_sequencer_if.sv
// Stream-side bundle of the BFP block sequencer: FP16 element input,
// flush request, and the registered BFP block output with its counter.
interface bfp_block_sequencer_if #(
  parameter int element_size  = 16,
  parameter int exponent_size = 5,
  parameter int mantissa_size = 10
);
  logic [element_size-1:0]  in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     flush;
  logic [mantissa_size:0]   out_sf0;
  logic [mantissa_size:0]   out_sf1;
  logic [mantissa_size:0]   out_sf2;
  logic [mantissa_size:0]   out_sf3;
  logic [3:0]               out_sign;
  logic [exponent_size-1:0] out_exp;
  logic [2:0]               out_count;
  logic                     out_valid;
  logic                     out_ready;
  logic [15:0]              block_count;

  // The sequencer itself
  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_sf0, out_sf1, out_sf2, out_sf3,
           out_sign, out_exp, out_count, out_valid, block_count
  );

  // Producer/consumer side
  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_sf0, out_sf1, out_sf2, out_sf3,
           out_sign, out_exp, out_count, out_valid, block_count
  );
endinterface

// File: rtl/bfp_block_sequencer.sv
// Gathers FP16 elements into 4-slot blocks, aligns them to a shared exponent
// and presents each block on a valid/ready output; supports partial-block flush.
module bfp_block_sequencer #(
  parameter int element_size  = 16,
  parameter int exponent_size = 5,
  parameter int mantissa_size = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bfp_block_sequencer_if.slave  bus
);

  localparam int SIG_W = mantissa_size + 1;

  typedef enum logic [1:0] {FILL, NORM, HOLD} state_t;

  state_t                   r_state;
  logic [element_size-1:0]  r_elem [4];
  logic [2:0]               r_idx;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [SIG_W-1:0]         r_sf [4];
  logic [3:0]               r_sign;
  logic [exponent_size-1:0] r_exp;
  logic [2:0]               r_count;
  logic [15:0]              r_block_count;

  logic                     w_accept;
  logic                     w_flush_take;
  logic                     w_close;
  logic [element_size-1:0]  w_slot [4];
  logic [exponent_size-1:0] w_e [4];
  logic [SIG_W-1:0]         w_sig [4];
  logic [exponent_size-1:0] w_shift [4];
  logic [SIG_W-1:0]         w_sf [4];
  logic [3:0]               w_sign;
  logic [exponent_size-1:0] w_max01;
  logic [exponent_size-1:0] w_max23;
  logic [exponent_size-1:0] w_max;

  assign w_accept     = (r_state == FILL) && r_in_ready && bus.in_valid;
  // A flush closes the block when it holds at least one element after this edge
  assign w_flush_take = (r_state == FILL) && bus.flush && (w_accept || (r_idx != 3'd0));
  assign w_close      = (w_accept && (r_idx == 3'd3)) || w_flush_take;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_elem[gi] <= '0;
        end else if (w_accept && (r_idx[1:0] == 2'(gi))) begin
          r_elem[gi] <= bus.in_data;
        end
      end

      // Unfilled slots read as +0 so they neither raise the shared exponent
      // nor contribute a significand or sign.
      assign w_slot[gi]  = (3'(gi) < r_idx) ? r_elem[gi] : '0;
      assign w_e[gi]     = w_slot[gi][element_size-2 -: exponent_size];
      assign w_sig[gi]   = {(w_e[gi] != '0), w_slot[gi][mantissa_size-1:0]};
      assign w_shift[gi] = w_max - w_e[gi];
      assign w_sf[gi]    = w_sig[gi] >> w_shift[gi];
      assign w_sign[gi]  = w_slot[gi][element_size-1];
    end
  endgenerate

  assign w_max01 = (w_e[0] > w_e[1]) ? w_e[0] : w_e[1];
  assign w_max23 = (w_e[2] > w_e[3]) ? w_e[2] : w_e[3];
  assign w_max   = (w_max01 > w_max23) ? w_max01 : w_max23;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FILL;
      r_idx         <= 3'd0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_sign        <= '0;
      r_exp         <= '0;
      r_count       <= 3'd0;
      r_block_count <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        r_sf[i] <= '0;
      end
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_idx <= r_idx + 3'd1;
          end
          if (w_close) begin
            r_state    <= NORM;
            r_in_ready <= 1'b0;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        NORM: begin
          for (int i = 0; i < 4; i++) begin
            r_sf[i] <= w_sf[i];
          end
          r_sign      <= w_sign;
          r_exp       <= w_max;
          r_count     <= r_idx;
          r_out_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_out_valid   <= 1'b0;
            r_block_count <= r_block_count + 16'd1;
            r_idx         <= 3'd0;
            r_in_ready    <= 1'b1;
            r_state       <= FILL;
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_sf0     = r_sf[0];
  assign bus.out_sf1     = r_sf[1];
  assign bus.out_sf2     = r_sf[2];
  assign bus.out_sf3     = r_sf[3];
  assign bus.out_sign    = r_sign;
  assign bus.out_exp     = r_exp;
  assign bus.out_count   = r_count;
  assign bus.block_count = r_block_count;

endmodule
